// File: rtl/mmio_bus_master.sv
// mmio_bus_master
//   Debug/boot initiator for the mmio memread/memwrite bus. Turns a byte
//   command stream (typically a UART RX) into single-word bus transactions
//   and returns read data as four bytes, MSB first, on a TX byte stream.
//
//   Commands (multi-byte fields big-endian):
//     0x57 'W' A3 A2 A1 A0 D3 D2 D1 D0   write word
//     0x52 'R' A3 A2 A1 A0               read word, reply D3 D2 D1 D0
//     0x77 'w' D3 D2 D1 D0               write to last_addr+4
//                                        (only with MMIO_MASTER_AUTOINC_EN)
//
//   Optional feature macro: MMIO_MASTER_AUTOINC_EN (adds the 'w' opcode).
//
// Ports
//   i_clk, i_reset_n           clock, async active-low reset
//   i_rx_data/i_rx_valid/o_rx_ready   command byte stream in
//   o_tx_data/o_tx_valid/i_tx_ready   response byte stream out
//   o_memread, o_memwrite      one-cycle bus strobes
//   o_mem_addr, o_mem_writedata, i_mem_readdata   bus address/data
//   o_busy                     high whenever not idle (bus mux select)
//   o_err_count                saturating error counter
module mmio_bus_master #(
    parameter int READ_LATENCY = 1,        // 1..4
    parameter int TIMEOUT      = 1000000,  // >= 2
    parameter int ERR_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_memread,
    output logic             o_memwrite,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_writedata,
    input  logic [31:0]      i_mem_readdata,
    output logic             o_busy,
    output logic [ERR_W-1:0] o_err_count
);
    localparam int          TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  OP_W  = 8'h57;
    localparam logic [7:0]  OP_R  = 8'h52;
`ifdef MMIO_MASTER_AUTOINC_EN
    localparam logic [7:0]  OP_WI = 8'h77;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_WAIT, S_TX
    } state_t;

    state_t           r_state;
    logic             r_is_write;
    logic [1:0]       r_cnt;        // byte counter in ADDR/DATA, byte index in TX
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic [31:0]      r_word;       // TX shift register
    logic [1:0]       r_wait;
    logic [TMR_W-1:0] r_timer;
    logic             r_rx_ready;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;
    logic             r_memread;
    logic             r_memwrite;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_writedata;
    logic [ERR_W-1:0] r_err_count;
`ifdef MMIO_MASTER_AUTOINC_EN
    logic [31:0]      r_last_addr;
`endif

    logic             w_rx_fire;
    logic             w_tx_fire;
    logic             w_timeout;
    logic [ERR_W-1:0] w_err_next;
    logic [31:0]      w_addr_full;
    logic [31:0]      w_data_full;

    assign w_rx_fire   = i_rx_valid & r_rx_ready;
    assign w_tx_fire   = r_tx_valid & i_tx_ready;
    // Timer holds the number of idle cycles already seen; this cycle is the last allowed one.
    assign w_timeout   = (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_err_next  = (&r_err_count) ? r_err_count : r_err_count + ERR_W'(1);
    assign w_addr_full = {r_addr[23:0], i_rx_data};
    assign w_data_full = {r_data[23:0], i_rx_data};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= S_IDLE;
            r_is_write      <= 1'b0;
            r_cnt           <= '0;
            r_addr          <= '0;
            r_data          <= '0;
            r_word          <= '0;
            r_wait          <= '0;
            r_timer         <= '0;
            r_rx_ready      <= 1'b0;
            r_tx_valid      <= 1'b0;
            r_tx_data       <= '0;
            r_memread       <= 1'b0;
            r_memwrite      <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_writedata <= '0;
            r_err_count     <= '0;
`ifdef MMIO_MASTER_AUTOINC_EN
            r_last_addr     <= '0;
`endif
        end else begin
            // Strobes are single-cycle: set on entry to WRITE/READ, dropped here.
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rx_ready <= 1'b1;
                    r_timer    <= '0;
                    r_cnt      <= '0;
                    if (w_rx_fire) begin
                        case (i_rx_data)
                            OP_W: begin r_is_write <= 1'b1; r_state <= S_ADDR; end
                            OP_R: begin r_is_write <= 1'b0; r_state <= S_ADDR; end
`ifdef MMIO_MASTER_AUTOINC_EN
                            OP_WI: begin
                                r_is_write <= 1'b1;
                                r_addr     <= r_last_addr + 32'd4;
                                r_state    <= S_DATA;
                            end
`endif
                            default: r_err_count <= w_err_next;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        r_timer <= '0;
                        r_addr  <= w_addr_full;
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_is_write) begin
                                r_state <= S_DATA;
                            end else if (i_rx_data[1:0] == 2'b00) begin
                                r_state    <= S_READ;
                                r_memread  <= 1'b1;
                                r_mem_addr <= w_addr_full;
                                r_rx_ready <= 1'b0;
`ifdef MMIO_MASTER_AUTOINC_EN
                                r_last_addr <= w_addr_full;
`endif
                            end else begin
                                // Unaligned read: no bus access, canned reply.
                                r_err_count <= w_err_next;
                                r_word      <= 32'hDEADBEEF;
                                r_tx_data   <= 8'hDE;
                                r_tx_valid  <= 1'b1;
                                r_rx_ready  <= 1'b0;
                                r_state     <= S_TX;
                            end
                        end
                    end else if (w_timeout) begin
                        r_err_count <= w_err_next;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_timer <= '0;
                        r_data  <= w_data_full;
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_addr[1:0] == 2'b00) begin
                                r_state         <= S_WRITE;
                                r_memwrite      <= 1'b1;
                                r_mem_addr      <= r_addr;
                                r_mem_writedata <= w_data_full;
                                r_rx_ready      <= 1'b0;
`ifdef MMIO_MASTER_AUTOINC_EN
                                r_last_addr     <= r_addr;
`endif
                            end else begin
                                r_err_count <= w_err_next;
                                r_state     <= S_IDLE;
                            end
                        end
                    end else if (w_timeout) begin
                        r_err_count <= w_err_next;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_WRITE: begin
                    r_state    <= S_IDLE;
                    r_rx_ready <= 1'b1;
                end
                S_READ: begin
                    r_wait  <= 2'(READ_LATENCY - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // The last WAIT cycle is READ_LATENCY cycles after the strobe:
                    // mem_readdata is sampled on the edge that closes it.
                    if (r_wait == 2'd0) begin
                        r_word     <= i_mem_readdata;
                        r_tx_data  <= i_mem_readdata[31:24];
                        r_tx_valid <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_TX;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                S_TX: begin
                    if (w_tx_fire) begin
                        r_word    <= {r_word[23:0], 8'h00};
                        r_tx_data <= r_word[23:16];
                        r_cnt     <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rx_ready      = r_rx_ready;
    assign o_tx_data       = r_tx_data;
    assign o_tx_valid      = r_tx_valid;
    assign o_memread       = r_memread;
    assign o_memwrite      = r_memwrite;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_writedata = r_mem_writedata;
    assign o_busy          = (r_state != S_IDLE);
    assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_mmio_bus_master.sv
// Self-checking bench for mmio_bus_master (READ_LATENCY=2, TIMEOUT=16).
// A transaction-level model predicts bus strobes, TX bytes and error count
// from the command bytes sent; a per-cycle monitor compares the DUT against it.
module tb_mmio_bus_master;
    localparam int RL = 2;
    localparam int TO = 16;
    localparam int EW = 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic [7:0]    i_rx_data = 8'h00;
    logic          i_rx_valid = 1'b0;
    logic          o_rx_ready;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready = 1'b0;
    logic          o_memread;
    logic          o_memwrite;
    logic [31:0]   o_mem_addr;
    logic [31:0]   o_mem_writedata;
    logic [31:0]   i_mem_readdata = 32'h0;
    logic          o_busy;
    logic [EW-1:0] o_err_count;

    mmio_bus_master #(.READ_LATENCY(RL), .TIMEOUT(TO), .ERR_W(EW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_memread(o_memread), .o_memwrite(o_memwrite),
        .o_mem_addr(o_mem_addr), .o_mem_writedata(o_mem_writedata),
        .i_mem_readdata(i_mem_readdata), .o_busy(o_busy), .o_err_count(o_err_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          tests = 0;
    int          fails = 0;
    int          m_err = 0;
    logic [31:0] m_last = 32'h0;
    bit          tx_auto = 1'b1;
    bit          tx_force = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory contents as seen on reads: a fixed hash, with 0x100 pinned.
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h100) return 32'hCAFEF00D;
        return (a ^ 32'h5A5A1234) * 32'h9E3779B1 + 32'h1;
    endfunction

    // mmio model: read data is valid only in the cycle RL cycles after the
    // memread cycle; every other cycle carries garbage.
    initial begin
        int          rd_cd;
        logic [31:0] rd_addr;
        rd_cd = 0;
        rd_addr = 32'h0;
        forever begin
            @(negedge i_clk);
            if (o_memread) begin rd_cd = RL; rd_addr = o_mem_addr; end
            @(posedge i_clk); #1;
            if (rd_cd == 1) i_mem_readdata = rd_val(rd_addr);
            else            i_mem_readdata = $urandom;
            if (rd_cd > 0) rd_cd--;
        end
    end

    // TX sink: random ready, or a forced level for directed tests.
    initial forever begin
        @(posedge i_clk); #2;
        i_tx_ready = tx_auto ? ($urandom_range(0, 3) != 0) : tx_force;
    end

    // Per-cycle monitor against the model queues.
    initial begin
        bit         prev_hold;
        logic [7:0] prev_tx;
        bus_t       e;
        prev_hold = 1'b0;
        prev_tx = 8'h0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                prev_hold = 1'b0;
            end else begin
                check("strobe_excl", {31'b0, o_memread & o_memwrite}, 0);
                if (o_memread | o_memwrite | o_tx_valid) begin
                    check("rx_ready_bp", {31'b0, o_rx_ready}, 0);
                    check("busy_active", {31'b0, o_busy}, 1);
                end
                if (o_memwrite) begin
                    check("wr_expected", {31'b0, exp_bus.size() != 0}, 1);
                    if (exp_bus.size() != 0) begin
                        e = exp_bus.pop_front();
                        check("wr_kind", {31'b0, e.wr}, 1);
                        check("wr_addr", o_mem_addr, e.addr);
                        check("wr_data", o_mem_writedata, e.data);
                    end
                end
                if (o_memread) begin
                    check("rd_expected", {31'b0, exp_bus.size() != 0}, 1);
                    if (exp_bus.size() != 0) begin
                        e = exp_bus.pop_front();
                        check("rd_kind", {31'b0, e.wr}, 0);
                        check("rd_addr", o_mem_addr, e.addr);
                    end
                end
                if (prev_hold) begin
                    check("tx_hold_valid", {31'b0, o_tx_valid}, 1);
                    check("tx_hold_data", o_tx_data, prev_tx);
                end
                if (o_tx_valid && i_tx_ready) begin
                    check("tx_expected", {31'b0, exp_tx.size() != 0}, 1);
                    if (exp_tx.size() != 0) check("tx_byte", o_tx_data, exp_tx.pop_front());
                end
                prev_hold = o_tx_valid && !i_tx_ready;
                prev_tx = o_tx_data;
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        i_rx_data = b;
        i_rx_valid = 1'b1;
        while (!acc && n < 400) begin
            @(negedge i_clk); acc = o_rx_ready;
            @(posedge i_clk); #1;
            n++;
        end
        i_rx_valid = 1'b0;
        if (!acc) check("rx_accept_timeout", 0, 1);
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int gmax);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gmax > 0 && i != q.size() - 1) gap($urandom_range(0, gmax));
        end
    endtask

    task automatic push_word_tx(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_and_check();
        int n;
        n = 0;
        do begin @(negedge i_clk); n++; end while (o_busy && n < 500);
        check("idle_reached", {31'b0, o_busy}, 0);
        check("bus_q_drained", exp_bus.size(), 0);
        check("tx_q_drained", exp_tx.size(), 0);
        check("err_count", {24'b0, o_err_count}, (m_err > 255) ? 255 : m_err);
        @(posedge i_clk); #1;
    endtask

    task automatic cmd_w(input logic [31:0] a, input logic [31:0] d, input int gmax);
        logic [7:0] q[$];
        if (a[1:0] == 2'b00) begin exp_bus.push_back('{1'b1, a, d}); m_last = a; end
        else m_err++;
        q.push_back(8'h57);
        for (int i = 3; i >= 0; i--) q.push_back(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) q.push_back(d[8*i +: 8]);
        send_seq(q, gmax);
    endtask

    task automatic cmd_r(input logic [31:0] a, input int gmax);
        logic [7:0] q[$];
        if (a[1:0] == 2'b00) begin
            exp_bus.push_back('{1'b0, a, 32'h0});
            push_word_tx(rd_val(a));
            m_last = a;
        end else begin
            m_err++;
            push_word_tx(32'hDEADBEEF);
        end
        q.push_back(8'h52);
        for (int i = 3; i >= 0; i--) q.push_back(a[8*i +: 8]);
        send_seq(q, gmax);
    endtask

    task automatic cmd_wi(input logic [31:0] d, input int gmax);
        logic [7:0] q[$];
        q.push_back(8'h77);
`ifdef MMIO_MASTER_AUTOINC_EN
        m_last = m_last + 32'd4;
        exp_bus.push_back('{1'b1, m_last, d});
        for (int i = 3; i >= 0; i--) q.push_back(d[8*i +: 8]);
`else
        m_err++;
`endif
        send_seq(q, gmax);
    endtask

    task automatic cmd_partial(input bit wr, input int k);
        logic [7:0] q[$];
        q.push_back(wr ? 8'h57 : 8'h52);
        for (int i = 0; i < k; i++) q.push_back(8'($urandom));
        m_err++;
        send_seq(q, 2);
        gap(TO + 3);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"}, {31'b0, o_rx_ready}, 0);
        check({tag, "_tx_valid"}, {31'b0, o_tx_valid}, 0);
        check({tag, "_tx_data"}, {24'b0, o_tx_data}, 0);
        check({tag, "_memread"}, {31'b0, o_memread}, 0);
        check({tag, "_memwrite"}, {31'b0, o_memwrite}, 0);
        check({tag, "_mem_addr"}, o_mem_addr, 0);
        check({tag, "_writedata"}, o_mem_writedata, 0);
        check({tag, "_busy"}, {31'b0, o_busy}, 0);
        check({tag, "_err"}, {24'b0, o_err_count}, 0);
    endtask

    task automatic model_reset();
        exp_bus.delete();
        exp_tx.delete();
        m_err = 0;
        m_last = 32'h0;
    endtask

    // Release reset between edges; rx_ready must rise only after the next edge.
    task automatic release_reset();
        @(posedge i_clk); #3;
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check("rx_ready_after_release_0", {31'b0, o_rx_ready}, 0);
        @(negedge i_clk);
        check("rx_ready_after_release_1", {31'b0, o_rx_ready}, 1);
        check("err_after_release", {24'b0, o_err_count}, 0);
        @(posedge i_clk); #1;
    endtask

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_reset_n = 1'b0;
        model_reset();
        gap(2);
        release_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        int          n;
        logic [31:0] a;
        logic [31:0] d;
        logic [7:0]  q[$];

        // Reset state
        #1;
        check_all_zero("reset");
        gap(3);
        release_reset();

        // Directed write: one memwrite cycle, busy drops the next cycle
        cmd_w(32'h00000010, 32'h12345678, 0);
        @(negedge i_clk);
        check("dw_memwrite", {31'b0, o_memwrite}, 1);
        check("dw_addr", o_mem_addr, 32'h00000010);
        check("dw_data", o_mem_writedata, 32'h12345678);
        check("dw_busy", {31'b0, o_busy}, 1);
        @(negedge i_clk);
        check("dw_memwrite_drop", {31'b0, o_memwrite}, 0);
        check("dw_busy_drop", {31'b0, o_busy}, 0);
        @(posedge i_clk); #1;
        wait_and_check();

        // Directed read at 0x100 (data 0xCAFEF00D), stall on the second byte
        tx_auto = 1'b0;
        tx_force = 1'b1;
        gap(2);
        exp_bus.push_back('{1'b0, 32'h00000100, 32'h0});
        exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
        q = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00};
        send_seq(q, 0);
        @(negedge i_clk);
        check("dr_memread", {31'b0, o_memread}, 1);
        check("dr_addr", o_mem_addr, 32'h00000100);
        n = 0;
        while (!o_tx_valid && n < 20) begin @(negedge i_clk); n++; end
        check("dr_tx_valid", {31'b0, o_tx_valid}, 1);
        check("dr_byte0", {24'b0, o_tx_data}, 32'hCA);
        @(posedge i_clk); #1;
        tx_force = 1'b0;
        repeat (5) begin
            @(negedge i_clk);
            check("dr_stall_valid", {31'b0, o_tx_valid}, 1);
            check("dr_stall_data", {24'b0, o_tx_data}, 32'hFE);
        end
        @(posedge i_clk); #1;
        tx_force = 1'b1;
        wait_and_check();
        tx_auto = 1'b1;

        // Errors: bad opcode, then unaligned read
        do_reset();
        send_byte(8'h41);
        m_err++;
        wait_and_check();
        check("err_badop_lit", {24'b0, o_err_count}, 1);
        cmd_r(32'h00000002, 0);
        wait_and_check();
        check("err_unaligned_lit", {24'b0, o_err_count}, 2);

        // Timeout: 57 00 then silence
        m_err++;
        q = '{8'h57, 8'h00};
        send_seq(q, 0);
        for (int i = 1; i <= 17; i++) begin
            @(negedge i_clk);
            if (i == 16) check("to_busy_before", {31'b0, o_busy}, 1);
            if (i == 17) check("to_busy_after", {31'b0, o_busy}, 0);
        end
        @(posedge i_clk); #1;
        wait_and_check();
        check("err_timeout_lit", {24'b0, o_err_count}, 3);

        // Reset in the middle of DATA: every output drops at once
        cmd_w(32'h00000030, 32'hA5A5A5A5, 0);
        wait_and_check();
        q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11, 8'h22};
        send_seq(q, 0);
        @(negedge i_clk);
        check("mid_data_busy", {31'b0, o_busy}, 1);
        #2 i_reset_n = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        release_reset();

        // Auto-increment write
        cmd_w(32'h00000020, 32'h11223344, 0);
        wait_and_check();
`ifdef MMIO_MASTER_AUTOINC_EN
        q = '{8'h77, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_bus.push_back('{1'b1, 32'h00000024, 32'hAABBCCDD});
        m_last = 32'h00000024;
        send_seq(q, 0);
        @(negedge i_clk);
        check("ai_memwrite", {31'b0, o_memwrite}, 1);
        check("ai_addr", o_mem_addr, 32'h00000024);
        check("ai_data", o_mem_writedata, 32'hAABBCCDD);
        @(posedge i_clk); #1;
        wait_and_check();
`else
        send_byte(8'h77);
        m_err++;
        wait_and_check();
        check("ai_disabled_err", {24'b0, o_err_count}, 1);
`endif

        // Randomized command mix
        for (int c = 0; c < 60; c++) begin
            kind = $urandom_range(0, 5);
            a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case (kind)
                0, 1: cmd_w(a, d, 3);
                2, 3: cmd_r(a, 3);
                4: begin
                    if ($urandom_range(0, 1) == 1) begin
                        cmd_wi(d, 3);
                    end else begin
                        do d[7:0] = 8'($urandom);
                        while (d[7:0] == 8'h57 || d[7:0] == 8'h52 || d[7:0] == 8'h77);
                        m_err++;
                        send_byte(d[7:0]);
                    end
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) cmd_partial(1'b1, $urandom_range(0, 7));
                    else                           cmd_partial(1'b0, $urandom_range(0, 3));
                end
            endcase
            if (kind == 5 || $urandom_range(0, 1) == 1) wait_and_check();
        end
        wait_and_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
